// File: rtl/ahb_pkg.sv
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-Lite encodings and the BRAM controller response
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] c_HSIZE_BYTE = 3'd0;
    localparam logic [2:0] c_HSIZE_HALF = 3'd1;
    localparam logic [2:0] c_HSIZE_WORD = 3'd2;

    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } resp_state_e;

endpackage

`default_nettype wire

// File: rtl/ahblite_bram_ctrl_if.sv
// ============================================================================
// Module      : ahblite_bram_ctrl_if
// Description : AHB-Lite slave-side bus bundle for the BRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ahblite_bram_ctrl_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HPROT, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HPROT, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

endinterface

`default_nettype wire

// File: rtl/ahblite_strb_dec.sv
// ============================================================================
// Module      : ahblite_strb_dec
// Description : Byte-lane strobe and alignment-legality decode of HSIZE and
//               the two low address bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahblite_strb_dec
    import ahb_pkg::*;
(
    input  wire logic [2:0] i_hsize,
    input  wire logic [1:0] i_addr,
    output logic      [3:0] o_strb,
    output logic            o_illegal
);

    always_comb begin
        o_strb    = 4'b0000;
        o_illegal = 1'b0;
        case (i_hsize)
            c_HSIZE_BYTE: o_strb = 4'b0001 << i_addr;
            c_HSIZE_HALF: begin
                if (i_addr[0]) o_illegal = 1'b1;
                else           o_strb    = i_addr[1] ? 4'b1100 : 4'b0011;
            end
            c_HSIZE_WORD: begin
                if (i_addr != 2'b00) o_illegal = 1'b1;
                else                 o_strb    = 4'b1111;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ahblite_bram_ctrl.sv
// ============================================================================
// Module      : ahblite_bram_ctrl
// Description : Zero-wait AHB-Lite slave in front of a simple dual-port BRAM,
//               with write-to-read forwarding and two-cycle ERROR responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahblite_bram_ctrl
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  wire logic                  HCLK,
    input  wire logic                  HRESET,
    ahblite_bram_ctrl_if.slave         ahb,
    output logic [ADDR_WIDTH-1:0]      BRAM_WADDR,
    output logic [31:0]                BRAM_WDATA,
    output logic [3:0]                 BRAM_WE,
    output logic [ADDR_WIDTH-1:0]      BRAM_RADDR,
    input  wire logic [31:0]           BRAM_RDATA
);

    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_legal_acc;
    logic [3:0]            w_strb;
    logic [ADDR_WIDTH-1:0] w_haddr_word;
    logic                  w_dp_wr;
    logic                  w_dp_rd;
    logic                  w_unused;

    resp_state_e           r_state;
    resp_state_e           w_state_nxt;

    logic                  r_dp_valid;
    logic                  r_dp_write;
    logic [3:0]            r_dp_strb;
    logic [ADDR_WIDTH-1:0] r_dp_addr;
    logic                  r_hit;
    logic [3:0]            r_fwd_strb;
    logic [31:0]           r_fwd_data;

    assign w_accept     = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign w_legal_acc  = w_accept & ~w_illegal;
    assign w_haddr_word = ahb.HADDR[ADDR_WIDTH+1:2];
    assign w_dp_wr      = r_dp_valid & r_dp_write;
    assign w_dp_rd      = r_dp_valid & ~r_dp_write;
    assign w_unused     = ^{ahb.HPROT, ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

    ahblite_strb_dec u_strb_dec (
        .i_hsize   (ahb.HSIZE),
        .i_addr    (ahb.HADDR[1:0]),
        .o_strb    (w_strb),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= ST_OKAY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        ahb.HREADYOUT = 1'b1;
        ahb.HRESP     = c_HRESP_OKAY;
        case (r_state)
            ST_OKAY: begin
                if (w_accept & w_illegal) w_state_nxt = ST_ERR1;
            end
            ST_ERR1: begin
                ahb.HREADYOUT = 1'b0;
                ahb.HRESP     = c_HRESP_ERROR;
                w_state_nxt   = ST_ERR2;
            end
            ST_ERR2: begin
                ahb.HRESP   = c_HRESP_ERROR;
                w_state_nxt = (w_accept & w_illegal) ? ST_ERR1 : ST_OKAY;
            end
            default: w_state_nxt = ST_OKAY;
        endcase
    end

    // The hit flag marks a read whose word is being written by the data phase in flight.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_strb  <= 4'b0000;
            r_hit      <= 1'b0;
            r_fwd_strb <= 4'b0000;
        end else if (ahb.HREADY) begin
            r_dp_valid <= w_legal_acc;
            r_dp_write <= w_legal_acc & ahb.HWRITE;
            r_dp_strb  <= w_legal_acc ? w_strb : 4'b0000;
            r_hit      <= w_legal_acc & ~ahb.HWRITE & w_dp_wr & (r_dp_addr == w_haddr_word);
            r_fwd_strb <= r_dp_strb;
        end
    end

    always_ff @(posedge HCLK) begin
        if (ahb.HREADY) begin
            if (w_accept) r_dp_addr <= w_haddr_word;
            r_fwd_data <= ahb.HWDATA;
        end
    end

    assign BRAM_WADDR = r_dp_addr;
    assign BRAM_WDATA = ahb.HWDATA;
    assign BRAM_WE    = w_dp_wr ? r_dp_strb : 4'b0000;
    assign BRAM_RADDR = ahb.HREADY ? w_haddr_word : r_dp_addr;

    always_comb begin
        ahb.HRDATA = 32'h0000_0000;
        if (w_dp_rd) begin
            for (int i = 0; i < 4; i++) begin
                ahb.HRDATA[8*i +: 8] = (r_hit & r_fwd_strb[i]) ? r_fwd_data[8*i +: 8]
                                                               : BRAM_RDATA[8*i +: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahblite_bram_ctrl.sv
// ============================================================================
// Module      : tb_ahblite_bram_ctrl
// Description : Scoreboard bench for ahblite_bram_ctrl with a BRAM model and
//               a byte-level reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahblite_bram_ctrl;
    import ahb_pkg::*;

    localparam int AW    = 12;
    localparam int WORDS = 1 << AW;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [AW-1:0] BRAM_WADDR;
    logic [AW-1:0] BRAM_RADDR;
    logic [31:0]   BRAM_WDATA;
    logic [31:0]   BRAM_RDATA;
    logic [3:0]    BRAM_WE;

    ahblite_bram_ctrl_if ahb();
    assign ahb.HREADY = ahb.HREADYOUT;

    ahblite_bram_ctrl #(.ADDR_WIDTH(AW)) u_dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .ahb        (ahb),
        .BRAM_WADDR (BRAM_WADDR),
        .BRAM_WDATA (BRAM_WDATA),
        .BRAM_WE    (BRAM_WE),
        .BRAM_RADDR (BRAM_RADDR),
        .BRAM_RDATA (BRAM_RDATA)
    );

    always #5 HCLK = ~HCLK;

    // Physical BRAM: registered read, old data on read-during-write.
    logic [31:0] bram [0:WORDS-1];
    initial for (int i = 0; i < WORDS; i++) bram[i] <= 32'h0;
    always @(posedge HCLK) begin
        for (int i = 0; i < 4; i++)
            if (BRAM_WE[i]) bram[BRAM_WADDR][8*i +: 8] <= BRAM_WDATA[8*i +: 8];
        BRAM_RDATA <= bram[BRAM_RADDR];
    end

    // Reference memory: word index -> contents, absent words read as zero.
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_read(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    function automatic bit ref_legal(input logic [2:0] size, input logic [31:0] addr);
        int nbytes;
        if (size > 3'd2) return 1'b0;
        nbytes = 1 << size;
        return (addr % nbytes) == 0;
    endfunction

    function automatic logic [3:0] ref_lanes(input logic [2:0] size, input logic [31:0] addr);
        logic [3:0] l;
        int first;
        l = 4'b0000;
        first = int'(addr % 4);
        for (int b = first; b < first + (1 << size); b++) l[b] = 1'b1;
        return l;
    endfunction

    typedef struct {
        bit            err;
        logic [31:0]   rdata;
        logic [3:0]    we;
        logic [AW-1:0] waddr;
        logic [31:0]   wdata;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b1;
    bit   pend_err2 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one address phase; the expected data-phase response is queued at acceptance.
    task automatic issue(input bit sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic [2:0] size, input bit wr, input logic [31:0] data);
        exp_t        e;
        int          guard;
        int          idx;
        bit          act;
        logic [3:0]  lanes;
        logic [31:0] w;
        ahb.HSEL   = sel;
        ahb.HTRANS = trans;
        ahb.HADDR  = addr;
        ahb.HSIZE  = size;
        ahb.HWRITE = wr;
        ahb.HPROT  = 4'($urandom);
        guard = 0;
        @(negedge HCLK);
        while (ahb.HREADYOUT !== 1'b1 && guard < 8) begin
            guard++;
            @(negedge HCLK);
        end
        if (guard == 8) begin
            n_checks++;
            n_fail++;
            $display("FAIL hready_timeout: got HREADYOUT=%b expected 1 at %0t", ahb.HREADYOUT, $time);
        end
        act     = sel && trans[1];
        idx     = int'((addr >> 2) % WORDS);
        e.err   = 1'b0;
        e.rdata = 32'h0;
        e.we    = 4'b0000;
        e.waddr = AW'(idx);
        e.wdata = data;
        if (act && !ref_legal(size, addr)) begin
            e.err = 1'b1;
        end else if (act && wr) begin
            lanes = ref_lanes(size, addr);
            e.we  = lanes;
            w     = ref_read(idx);
            for (int b = 0; b < 4; b++)
                if (lanes[b]) w[8*b +: 8] = data[8*b +: 8];
            ref_mem[idx] = w;
        end else if (act) begin
            e.rdata = ref_read(idx);
        end
        @(posedge HCLK);
        sbq.push_back(e);
        #1;
        ahb.HWDATA = (act && wr && !e.err) ? data : $urandom;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) issue(1'b1, c_HTRANS_IDLE, 32'h0, c_HSIZE_WORD, 1'b0, 32'h0);
    endtask

    always @(negedge HCLK) begin
        exp_t e;
        if (!mon_en) begin
            pend_err2 = 1'b0;
        end else if (pend_err2) begin
            pend_err2 = 1'b0;
            chk("err2_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
            chk("err2_hresp",     32'(ahb.HRESP),     32'd1);
            chk("err2_we",        32'(BRAM_WE),       32'd0);
        end else if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.err) begin
                chk("err1_hreadyout", 32'(ahb.HREADYOUT), 32'd0);
                chk("err1_hresp",     32'(ahb.HRESP),     32'd1);
                chk("err1_we",        32'(BRAM_WE),       32'd0);
                pend_err2 = 1'b1;
            end else begin
                chk("ok_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
                chk("ok_hresp",     32'(ahb.HRESP),     32'd0);
                chk("bram_we",      32'(BRAM_WE),       32'(e.we));
                chk("hrdata",       ahb.HRDATA,         e.rdata);
                if (e.we != 4'b0000) begin
                    chk("bram_waddr", 32'(BRAM_WADDR), 32'(e.waddr));
                    chk("bram_wdata", BRAM_WDATA,      e.wdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        HRESET     = 1'b1;
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = c_HTRANS_IDLE;
        ahb.HADDR  = 32'h0;
        ahb.HSIZE  = c_HSIZE_WORD;
        ahb.HWRITE = 1'b0;
        ahb.HPROT  = 4'h0;
        ahb.HWDATA = 32'h0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
        chk("rst_hresp",     32'(ahb.HRESP),     32'd0);
        chk("rst_we",        32'(BRAM_WE),       32'd0);
        chk("rst_hrdata",    ahb.HRDATA,         32'd0);
        @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Word write then read, forwarded and from BRAM.
        issue(1'b1, c_HTRANS_NONSEQ, 32'h10, c_HSIZE_WORD, 1'b1, 32'hDEADBEEF);
        issue(1'b1, c_HTRANS_NONSEQ, 32'h10, c_HSIZE_WORD, 1'b0, 32'h0);
        idle_n(1);
        issue(1'b1, c_HTRANS_NONSEQ, 32'h10, c_HSIZE_WORD, 1'b0, 32'h0);
        // Byte write into lane 3.
        issue(1'b1, c_HTRANS_NONSEQ, 32'h10, c_HSIZE_WORD, 1'b1, 32'h11223344);
        idle_n(1);
        issue(1'b1, c_HTRANS_NONSEQ, 32'h13, c_HSIZE_BYTE, 1'b1, 32'hAAAAAAAA);
        idle_n(1);
        issue(1'b1, c_HTRANS_NONSEQ, 32'h10, c_HSIZE_WORD, 1'b0, 32'h0);
        // Halfword write immediately followed by a read of the same word.
        issue(1'b1, c_HTRANS_NONSEQ, 32'h22, c_HSIZE_HALF, 1'b1, 32'h55665566);
        issue(1'b1, c_HTRANS_NONSEQ, 32'h20, c_HSIZE_WORD, 1'b0, 32'h0);
        // Misaligned word write, then the neighbouring word is untouched.
        issue(1'b1, c_HTRANS_NONSEQ, 32'h06, c_HSIZE_WORD, 1'b1, 32'h12345678);
        idle_n(1);
        issue(1'b1, c_HTRANS_NONSEQ, 32'h04, c_HSIZE_WORD, 1'b0, 32'h0);
        // Oversized read, then idle; then back-to-back illegal transfers.
        issue(1'b1, c_HTRANS_NONSEQ, 32'h40, 3'd3, 1'b0, 32'h0);
        issue(1'b1, c_HTRANS_IDLE,   32'h40, c_HSIZE_WORD, 1'b0, 32'h0);
        issue(1'b1, c_HTRANS_SEQ,    32'h41, c_HSIZE_HALF, 1'b0, 32'h0);
        issue(1'b1, c_HTRANS_SEQ,    32'h42, c_HSIZE_WORD, 1'b1, 32'h0);
        issue(1'b1, c_HTRANS_BUSY,   32'h42, c_HSIZE_WORD, 1'b0, 32'h0);
        idle_n(2);

        // Reset sampled at the acceptance edge of a write to 0x30.
        @(negedge HCLK);
        #1 mon_en = 1'b0;
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = c_HTRANS_NONSEQ;
        ahb.HADDR  = 32'h30;
        ahb.HSIZE  = c_HSIZE_WORD;
        ahb.HWRITE = 1'b1;
        HRESET     = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET     = 1'b0;
        ahb.HWDATA = 32'hCAFEF00D;
        ahb.HTRANS = c_HTRANS_IDLE;
        @(negedge HCLK);
        chk("rst_wr_we",        32'(BRAM_WE),       32'd0);
        chk("rst_wr_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
        chk("rst_wr_hresp",     32'(ahb.HRESP),     32'd0);
        // Reset while the first error cycle is showing.
        ahb.HTRANS = c_HTRANS_NONSEQ;
        ahb.HSIZE  = 3'd3;
        ahb.HWRITE = 1'b0;
        @(posedge HCLK);
        #1 ahb.HTRANS = c_HTRANS_IDLE;
        @(negedge HCLK);
        chk("err1_pre_rst_hreadyout", 32'(ahb.HREADYOUT), 32'd0);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        chk("err1_rst_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
        chk("err1_rst_hresp",     32'(ahb.HRESP),     32'd0);
        chk("err1_rst_we",        32'(BRAM_WE),       32'd0);
        mon_en = 1'b1;
        issue(1'b1, c_HTRANS_NONSEQ, 32'h30, c_HSIZE_WORD, 1'b0, 32'h0);

        // Randomised traffic over a small window with aliased upper address bits.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            logic [1:0]  tr;
            int          r;
            a  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            r  = $urandom_range(0, 7);
            tr = (r == 0) ? c_HTRANS_IDLE : (r == 1) ? c_HTRANS_BUSY :
                 (r < 5)  ? c_HTRANS_NONSEQ : c_HTRANS_SEQ;
            issue($urandom_range(0, 7) != 0, tr, a, sz, 1'($urandom_range(0, 1)), $urandom);
        end
        idle_n(3);
        @(negedge HCLK);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahblite_bram_ctrl.md
AHBLITE_BRAM_CTRL -- requirements
Module: ahblite_bram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning the BRAM word-address width (4*2^ADDR_WIDTH bytes).
REQ-002 SHALL have port HCLK, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port HRESET, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have AHB-Lite slave inputs: HSEL 1, HADDR 32, HTRANS 2, HSIZE 3, HWRITE 1, HPROT 4 (ignored), HWDATA 32, HREADY 1.
REQ-005 SHALL have AHB-Lite slave outputs: HREADYOUT 1, HRESP 1 (0=OKAY, 1=ERROR), HRDATA 32.
REQ-006 SHALL have BRAM write-port outputs: BRAM_WADDR ADDR_WIDTH, BRAM_WDATA 32, BRAM_WE 4 (byte enables, bit i = bits 8i+7:8i).
REQ-007 SHALL have BRAM read-port output BRAM_RADDR ADDR_WIDTH and input BRAM_RDATA 32, with one-cycle registered read latency and old-data read-during-write.

Function
REQ-008 SHALL accept a transfer when HSEL & HREADY & HTRANS[1] are all 1 at a rising edge; IDLE/BUSY transfers get a zero-wait OKAY response.
REQ-009 SHALL decode byte strobes at acceptance: HSIZE=0 -> one lane per HADDR[1:0]; HSIZE=1 -> lanes {1,0} or {3,2} per HADDR[1]; HSIZE=2 -> 4'b1111.
REQ-010 SHALL treat as illegal: HSIZE>2; HSIZE=1 with HADDR[0]=1; HSIZE=2 with HADDR[1:0]!=0.
REQ-011 SHALL answer an illegal transfer with a two-cycle ERROR: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1; then back to OKAY.
REQ-012 SHALL implement the response FSM with states OKAY -> ERR1 (illegal accepted) -> ERR2 -> OKAY; ERR2 -> ERR1 only if another illegal transfer is accepted in ERR2.
REQ-013 SHALL never assert BRAM_WE for an illegal transfer.
REQ-014 SHALL hold HREADYOUT=1 and HRESP=0 in state OKAY: legal reads and writes complete with zero wait states.
REQ-015 SHALL drive the write in the write data phase: BRAM_WADDR = registered HADDR[ADDR_WIDTH+1:2], BRAM_WDATA = HWDATA, BRAM_WE = registered strobes; all BRAM_WE zero otherwise.
REQ-016 SHALL drive BRAM_RADDR = HADDR[ADDR_WIDTH+1:2] while HREADY=1, else the registered word address of the current data phase.
REQ-017 SHALL present HRDATA = BRAM_RDATA in the read data phase; HRDATA is don't-care but SHALL be 0 outside read data phases.
REQ-018 SHALL forward data when a read address phase coincides with a write data phase to the same word.
REQ-019 Forwarding: register the write data, strobes and a hit flag; in the read data phase, each lane with strobe set takes the forwarded byte, the other lanes take BRAM_RDATA.
REQ-020 SHALL ignore HADDR bits above ADDR_WIDTH+1, which aliases the memory.
REQ-021 Back-to-back write, read, write to any mix of addresses SHALL sustain one transfer per cycle.

Reset
REQ-022 While HRESET=1 at an edge: FSM=OKAY, data-phase valid/write/hit flags=0, registered strobes=0.
REQ-023 Out of reset, HREADYOUT=1, HRESP=0, BRAM_WE=0, HRDATA=0.
REQ-024 Reset asserted mid-transfer (including ERR1) SHALL abort it without any BRAM write on the following cycle.
REQ-025 Memory contents are not cleared by reset.

Structure
REQ-026 HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), HSIZE encodings and the HRESP values SHALL live in shared package ahb_pkg.
REQ-027 Strobe and legality decode SHALL be one sub-module ahblite_strb_dec (HSIZE, HADDR[1:0] -> strobe[3:0], illegal); everything else is flat.
REQ-028 Expected size: 150-250 lines of RTL.

Verification
REQ-029 Word write 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF, zero waits, HRESP=0.
REQ-030 Byte write 0xAA to 0x13 over word 0x11223344, then read 0x10 -> 0xAA223344; BRAM_WE=4'b1000 in the write data phase.
REQ-031 Halfword write 0x5566 to 0x22 immediately followed by a read of 0x20 (old 0x00000000) -> HRDATA=0x55660000 via forwarding.
REQ-032 Word write to 0x06 (misaligned) -> ERR1 then ERR2, HRESP=1 for 2 cycles, BRAM_WE stays 0, and a later read of 0x04 is unchanged.
REQ-033 HRESET pulsed during the data phase of a write to 0x30 -> no BRAM_WE, HREADYOUT=1, HRESP=0 next cycle.
REQ-034 HSIZE=3 read, then IDLE with HSEL=1 -> ERROR twice, then an OKAY zero-wait response.
